// File: rtl/zymason_seg_loader.sv
// Write sequencer for the Zymason 12-digit segment store: FIFO-buffered digits are replayed as
// the LO/HI/ADV write cycle, then EX1/EX2 return the store to SCAN. Optional: ZYMASON_HEXDEC_EN.
module zymason_seg_loader #(
  parameter int DEPTH      = 4,
  parameter int NUM_DIGITS = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_data,
  input  logic [4:0] spd,
  output logic       RW,
  output logic       sel,
  output logic [3:0] pin_in,
  output logic       busy,
  output logic [3:0] wr_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef ZYMASON_HEXDEC_EN
  localparam int DW = 4;
`else
  localparam int DW = 7;
`endif
  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_ADV, S_EX1, S_EX2} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [6:0]    seg, pop_seg;
  logic          push, pop;

  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = ((state == S_IDLE) || (state == S_ADV)) && (count != '0);

  // NOTE: storage entries carry no reset; emptiness is defined by count/pointers alone.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data[DW-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ZYMASON_HEXDEC_EN
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign pop_seg = hex_to_seg(mem[rd_ptr]);
`else
  assign pop_seg = mem[rd_ptr];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      seg    <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) seg <= pop_seg;
      // ADV always lasts exactly one cycle, so being in ADV marks the edge that leaves it.
      if (state == S_ADV) wr_cnt <= (wr_cnt == LAST_DIGIT) ? 4'd0 : wr_cnt + 4'd1;
    end
  end

  // NOTE: combinational blocks use blocking assignments and assign a default first, so no latch forms.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = S_LO;
      S_LO:    state_nxt = S_HI;
      S_HI:    state_nxt = S_ADV;
      S_ADV:   state_nxt = (count != '0) ? S_LO : S_EX1;
      S_EX1:   state_nxt = S_EX2;
      S_EX2:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs come from state and seg only; spd is passed through while idle.
  always_comb begin
    RW     = 1'b0;
    sel    = spd[0];
    pin_in = spd[4:1];
    busy   = (state != S_IDLE);
    case (state)
      S_LO, S_ADV: begin
        RW     = 1'b1;
        sel    = 1'b0;
        pin_in = seg[3:0];
      end
      S_HI: begin
        RW     = 1'b1;
        sel    = 1'b1;
        pin_in = {1'b0, seg[6:4]};
      end
      S_EX1: begin
        sel    = 1'b1;
        pin_in = 4'd0;
      end
      S_EX2: begin
        sel    = 1'b0;
        pin_in = 4'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zymason_seg_loader.sv
// Randomised bench for zymason_seg_loader: a queue-based schedule model predicts every output,
// and a store observer rebuilds the digits the downstream store would capture.
module tb_zymason_seg_loader;

  localparam int DEPTH      = 4;
  localparam int NUM_DIGITS = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid, in_ready;
  logic [6:0] in_data;
  logic [4:0] spd;
  logic       RW, sel, busy;
  logic [3:0] pin_in, wr_cnt;

  always #5 clock = ~clock;

  zymason_seg_loader #(.DEPTH(DEPTH), .NUM_DIGITS(NUM_DIGITS)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .spd(spd), .RW(RW), .sel(sel), .pin_in(pin_in),
    .busy(busy), .wr_cnt(wr_cnt)
  );

  typedef struct packed {logic rw; logic sel; logic [3:0] pin; logic adv;} step_t;

  step_t      plan[$];
  logic [6:0] fq[$];
  int         m_wr;
  logic [6:0] hex_tbl [16];
  logic [6:0] store [NUM_DIGITS];
  logic [3:0] obs_lo;
  bit         obs_hi;
  int         obs_pos;
  int         busy_cycles;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic rw, input logic s, input logic [3:0] p, input logic adv);
    return {rw, s, p, adv};
  endfunction

  function automatic logic [6:0] enc(input logic [6:0] d);
`ifdef ZYMASON_HEXDEC_EN
    return hex_tbl[d[3:0]];
`else
    return d;
`endif
  endfunction

  function automatic logic [6:0] code_for(input int i);
`ifdef ZYMASON_HEXDEC_EN
    return 7'(i);
`else
    return hex_tbl[i];
`endif
  endfunction

  task automatic compare_outputs();
    if (plan.size() == 0) begin
      check("RW", RW, 0);
      check("sel", sel, spd[0]);
      check("pin_in", pin_in, spd[4:1]);
    end else begin
      check("RW", RW, plan[0].rw);
      check("sel", sel, plan[0].sel);
      check("pin_in", pin_in, plan[0].pin);
    end
    check("busy", busy, plan.size() != 0);
    check("in_ready", in_ready, fq.size() < DEPTH);
    check("wr_cnt", wr_cnt, m_wr);
  endtask

  // Rebuilds what the store captures: LO gives the low nibble, HI completes the digit, ADV moves on.
  task automatic observe();
    if (RW && sel) begin
      store[obs_pos] = {pin_in[2:0], obs_lo};
      obs_hi = 1'b1;
    end else if (RW && obs_hi) begin
      obs_pos = (obs_pos + 1) % NUM_DIGITS;
      obs_hi  = 1'b0;
    end else if (RW) begin
      obs_lo = pin_in;
    end
  endtask

  task automatic model_edge(input bit v, input logic [6:0] d, output bit acc);
    bit idle, was_adv, pop_ok;
    logic [6:0] s;
    idle    = (plan.size() == 0);
    was_adv = !idle && plan[0].adv;
    pop_ok  = (idle || was_adv) && (fq.size() > 0);
    acc     = v && (fq.size() < DEPTH);
    if (!idle) void'(plan.pop_front());
    if (was_adv) m_wr = (m_wr + 1) % NUM_DIGITS;
    if (pop_ok) begin
      s = fq.pop_front();
      plan.push_back(mk(1, 0, s[3:0], 0));
      plan.push_back(mk(1, 1, {1'b0, s[6:4]}, 0));
      plan.push_back(mk(1, 0, s[3:0], 1));
    end else if (was_adv) begin
      plan.push_back(mk(0, 1, 4'd0, 0));
      plan.push_back(mk(0, 0, 4'd0, 0));
    end
    if (acc) fq.push_back(enc(d));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input bit v, input logic [6:0] d, output bit acc);
    in_valid = v;
    in_data  = d;
    #1;
    compare_outputs();
    observe();
    if (busy) busy_cycles++;
    @(posedge clock);
    model_edge(v, d, acc);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_RW", RW, 0);
    check("rst_sel", sel, spd[0]);
    check("rst_pin_in", pin_in, spd[4:1]);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    plan.delete();
    fq.delete();
    m_wr    = 0;
    obs_pos = 0;
    obs_hi  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [6:0] d);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      tick(1, d, acc);
      tries++;
    end
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic drain(input int max);
    bit acc;
    int n;
    n = 0;
    while ((plan.size() != 0 || fq.size() != 0 || busy) && n < max) begin
      tick(0, 7'h00, acc);
      n++;
    end
    if (n >= max) check("drain_timeout", 0, 1);
    tick(0, 7'h00, acc);
  endtask

  initial begin
    bit acc, saw_full;
    int n;
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    in_valid = 1'b0;
    in_data  = '0;
    spd      = 5'b10111;
    m_wr     = 0;
    obs_pos  = 0;
    obs_hi   = 1'b0;
    obs_lo   = '0;
    @(negedge clock);

    // Reset state with a known scan speed.
    do_reset();
    tick(0, 7'h00, acc);
    check("idle_sel", sel, 1);
    check("idle_pin_in", pin_in, 4'b1011);

    // Single digit 5B.
    push_one(code_for(2));
    drain(30);
    check("single_wr_cnt", wr_cnt, 1);
    check("single_store0", store[0], 7'h5B);
    check("single_pos", obs_pos, 1);

    // Twelve digits back-to-back: FIFO fills, count wraps, 3N+2 busy cycles.
    do_reset();
    busy_cycles = 0;
    saw_full    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (fq.size() == DEPTH) saw_full = 1'b1;
      push_one(code_for(i));
    end
    drain(60);
    check("burst_saw_full", saw_full, 1);
    check("burst_busy_cycles", busy_cycles, 38);
    check("burst_wr_cnt", wr_cnt, 0);
    for (int i = 0; i < NUM_DIGITS; i++) check("burst_store", store[i], hex_tbl[i]);

    // Four pushes starting in EX1: exit sequence completes before the next LO.
    do_reset();
    push_one(code_for(7));
    n = 0;
    while (!(plan.size() != 0 && !plan[0].rw && plan[0].sel) && n < 20) begin
      tick(0, 7'h00, acc);
      n++;
    end
    check("reach_ex1", n < 20, 1);
    for (int i = 0; i < 4; i++) push_one(code_for(8 + i));
    drain(40);
    check("ex1_wr_cnt", wr_cnt, 5);
    for (int i = 0; i < 4; i++) check("ex1_store", store[1 + i], hex_tbl[8 + i]);

    // Reset during HI of the second digit; next digit lands in position 0.
    do_reset();
    push_one(code_for(3));
    push_one(code_for(4));
    n = 0;
    while (!(m_wr == 1 && plan.size() != 0 && plan[0].rw && plan[0].sel) && n < 20) begin
      tick(0, 7'h00, acc);
      n++;
    end
    check("reach_hi2", n < 20, 1);
    do_reset();
    tick(0, 7'h00, acc);
    tick(0, 7'h00, acc);
    push_one(code_for(1));
    drain(30);
    check("post_rst_store0", store[0], 7'h06);
    check("post_rst_wr_cnt", wr_cnt, 1);

    // Randomised traffic with bursty and sparse phases and varying scan speed.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      spd = 5'($urandom);
      if ((i / 100) % 2 == 0) tick($urandom_range(0, 3) != 0, 7'($urandom), acc);
      else                    tick($urandom_range(0, 5) == 0, 7'($urandom), acc);
    end
    drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
